// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// multicycle_ctrl
//   Control FSM for a multicycle MIPS-style datapath. It sequences fetch,
//   decode and the per-class execute/memory/writeback steps, and drives the
//   datapath strobes and mux selects for each step. It also counts retired
//   instructions and flags unsupported opcodes.
//
// Ports
//   clk_i          in   clock, all state updates on the rising edge
//   rst_i          in   asynchronous reset, active low
//   opcode_i[5:0]  in   instruction[31:26] from the instruction register
//   funct_i[5:0]   in   instruction[5:0] from the instruction register
//   mem_ready_i    in   memory finishes the current read/write this cycle
//   PCWrite_o .. ALUSrcA_o     out  1-bit datapath strobes / selects
//   ALUSrcB_o[1:0], PCSource_o[1:0]  out  mux selects
//   ALUOp_o[2:0]   out  0 add, 1 sub, 2 funct-decode, 3 addi, 4 slti, 5 jump
//   state_o[3:0]   out  current FSM state (debug)
//   illegal_o      out  high for the single DECODE cycle of an unsupported opcode
//   retired_o[15:0] out completed-instruction count, wraps at 16 bits
//
// Handshake: mem_ready_i is sampled in FETCH, MEMRD and MEMWR only; while it
// is low the FSM holds in that state with the same outputs, and the step
// completes on the rising edge where mem_ready_i is high.
module multicycle_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        PCWriteCond_o,
    output logic        IorD_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        IRWrite_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic        RegDst_o,
    output logic        ALUSrcA_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [1:0]  PCSource_o,
    output logic [2:0]  ALUOp_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic [15:0] retired_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t      state_q;
    state_t      state_d;
    logic        retire;
    logic [15:0] retired_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        RegDst_o      = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        PCSource_o    = 2'b00;
        ALUOp_o       = 3'd0;
        illegal_o     = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                // IR load and PC+4 happen only on the edge the read completes.
                if (mem_ready_i) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                ALUSrcB_o = 2'b11;
                case (opcode_i)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = (funct_i == FN_JR) ? S_JR : S_REX;
                    OP_BEQ:           state_d = S_BEQ;
                    OP_ADDI, OP_SLTI: state_d = S_IEX;
                    OP_J:             state_d = S_JUMP;
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_d   = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD_o    = 1'b1;
                MemRead_o = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                IorD_o     = 1'b1;
                MemWrite_o = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_REX: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 3'd2;
                state_d   = S_RWB;
            end
            S_RWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 3'd1;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_IEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = (opcode_i == OP_SLTI) ? 3'd4 : 3'd3;
                state_d   = S_IWB;
            end
            S_IWB: begin
                RegWrite_o = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                ALUOp_o    = 3'd5;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                ALUSrcA_o  = 1'b1;
                ALUOp_o    = 3'd2;
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b11;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            // Unused codes 13-15 recover to FETCH.
            default: state_d = S_FETCH;
        endcase
    end

    // Wraps naturally from 0xFFFF to 0x0000.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retired_q <= 16'd0;
        end else if (retire) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [5:0]  opcode_i = 6'b100011;
    logic [5:0]  funct_i = 6'd0;
    logic        mem_ready_i = 1'b1;
    logic        PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o;
    logic        IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o;
    logic [1:0]  ALUSrcB_o, PCSource_o;
    logic [2:0]  ALUOp_o;
    logic [3:0]  state_o;
    logic        illegal_o;
    logic [15:0] retired_o;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    multicycle_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .opcode_i      (opcode_i),
        .funct_i       (funct_i),
        .mem_ready_i   (mem_ready_i),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .IorD_o        (IorD_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .IRWrite_o     (IRWrite_o),
        .MemtoReg_o    (MemtoReg_o),
        .RegWrite_o    (RegWrite_o),
        .RegDst_o      (RegDst_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .PCSource_o    (PCSource_o),
        .ALUOp_o       (ALUOp_o),
        .state_o       (state_o),
        .illegal_o     (illegal_o),
        .retired_o     (retired_o)
    );

    // Strobe order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
    //               MemtoReg RegWrite RegDst ALUSrcA
    logic [31:0] obs_ctl;
    assign obs_ctl = {14'd0, PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
                      IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o,
                      ALUSrcB_o, PCSource_o, ALUOp_o, illegal_o};

    function automatic logic [31:0] ctl(input logic [9:0] strobes, input logic [1:0] asb,
                                        input logic [1:0] pcs, input logic [2:0] aop,
                                        input logic ill);
        return {14'd0, strobes, asb, pcs, aop, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive mem_ready at the falling edge, then let outputs settle before checks.
    task automatic cyc(input logic rdy);
        @(negedge clk_i);
        mem_ready_i = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_retired", 32'(retired_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
    endtask

    initial begin
        // ---- reset state and release behaviour ----
        #2;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_retired", 32'(retired_o), 32'd0);
        chk("reset_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        mem_ready_i = 1'b0;
        #1;
        chk("fetch_wait_ctl", obs_ctl, ctl(10'b0001000000, 2'b01, 2'b00, 3'd0, 1'b0));
        cyc(1'b1);
        chk("fetch_wait_hold", 32'(state_o), 32'd0);
        chk("fetch_ready_ctl", obs_ctl, ctl(10'b1001010000, 2'b01, 2'b00, 3'd0, 1'b0));

        // ---- lw, no wait: 0,1,2,3,4,0 ----
        cyc(1'b1);
        chk("lw_decode_state", 32'(state_o), 32'd1);
        chk("lw_decode_ctl", obs_ctl, ctl(10'b0000000000, 2'b11, 2'b00, 3'd0, 1'b0));
        cyc(1'b1);
        chk("lw_memadr_state", 32'(state_o), 32'd2);
        chk("lw_memadr_ctl", obs_ctl, ctl(10'b0000000001, 2'b10, 2'b00, 3'd0, 1'b0));
        cyc(1'b1);
        chk("lw_memrd_state", 32'(state_o), 32'd3);
        chk("lw_memrd_ctl", obs_ctl, ctl(10'b0011000000, 2'b00, 2'b00, 3'd0, 1'b0));
        cyc(1'b1);
        chk("lw_memwb_state", 32'(state_o), 32'd4);
        chk("lw_memwb_ctl", obs_ctl, ctl(10'b0000001100, 2'b00, 2'b00, 3'd0, 1'b0));
        chk("lw_memwb_retired", 32'(retired_o), 32'd0);
        cyc(1'b1);
        chk("lw_done_state", 32'(state_o), 32'd0);
        chk("lw_done_retired", 32'(retired_o), 32'd1);

        // ---- sw, two wait cycles in MEMWR: 6 cycles total ----
        opcode_i = 6'b101011;
        cyc(1'b1);
        chk("sw_decode_state", 32'(state_o), 32'd1);
        cyc(1'b1);
        chk("sw_memadr_state", 32'(state_o), 32'd2);
        cyc(1'b0);
        chk("sw_memwr1_state", 32'(state_o), 32'd5);
        chk("sw_memwr1_ctl", obs_ctl, ctl(10'b0010100000, 2'b00, 2'b00, 3'd0, 1'b0));
        cyc(1'b0);
        chk("sw_memwr2_ctl", obs_ctl, ctl(10'b0010100000, 2'b00, 2'b00, 3'd0, 1'b0));
        cyc(1'b1);
        chk("sw_memwr3_ctl", obs_ctl, ctl(10'b0010100000, 2'b00, 2'b00, 3'd0, 1'b0));
        chk("sw_memwr3_retired", 32'(retired_o), 32'd1);
        cyc(1'b1);
        chk("sw_done_state", 32'(state_o), 32'd0);
        chk("sw_done_retired", 32'(retired_o), 32'd2);

        // ---- R-type add, then jr ----
        opcode_i = 6'b000000;
        funct_i  = 6'b100000;
        do_reset();
        cyc(1'b1);
        chk("rt_decode_state", 32'(state_o), 32'd1);
        cyc(1'b1);
        chk("rt_rex_state", 32'(state_o), 32'd6);
        chk("rt_rex_ctl", obs_ctl, ctl(10'b0000000001, 2'b00, 2'b00, 3'd2, 1'b0));
        cyc(1'b1);
        chk("rt_rwb_state", 32'(state_o), 32'd7);
        chk("rt_rwb_ctl", obs_ctl, ctl(10'b0000000110, 2'b00, 2'b00, 3'd0, 1'b0));
        cyc(1'b1);
        chk("rt_done_retired", 32'(retired_o), 32'd1);
        funct_i = 6'b001000;
        cyc(1'b1);
        chk("jr_decode_state", 32'(state_o), 32'd1);
        cyc(1'b1);
        chk("jr_state", 32'(state_o), 32'd12);
        chk("jr_ctl", obs_ctl, ctl(10'b1000000001, 2'b00, 2'b11, 3'd2, 1'b0));
        cyc(1'b1);
        chk("jr_done_state", 32'(state_o), 32'd0);
        chk("jr_done_retired", 32'(retired_o), 32'd2);

        // ---- beq, slti, addi ----
        opcode_i = 6'b000100;
        funct_i  = 6'd0;
        cyc(1'b1);
        cyc(1'b1);
        chk("beq_state", 32'(state_o), 32'd8);
        chk("beq_ctl", obs_ctl, ctl(10'b0100000001, 2'b00, 2'b01, 3'd1, 1'b0));
        cyc(1'b1);
        chk("beq_done_retired", 32'(retired_o), 32'd3);
        opcode_i = 6'b001010;
        cyc(1'b1);
        cyc(1'b1);
        chk("slti_iex_state", 32'(state_o), 32'd9);
        chk("slti_iex_ctl", obs_ctl, ctl(10'b0000000001, 2'b10, 2'b00, 3'd4, 1'b0));
        cyc(1'b1);
        chk("slti_iwb_state", 32'(state_o), 32'd10);
        chk("slti_iwb_ctl", obs_ctl, ctl(10'b0000000100, 2'b00, 2'b00, 3'd0, 1'b0));
        cyc(1'b1);
        chk("slti_done_retired", 32'(retired_o), 32'd4);
        opcode_i = 6'b001000;
        cyc(1'b1);
        cyc(1'b1);
        chk("addi_iex_ctl", obs_ctl, ctl(10'b0000000001, 2'b10, 2'b00, 3'd3, 1'b0));

        // ---- illegal opcode ----
        cyc(1'b1);
        cyc(1'b1);
        chk("addi_done_retired", 32'(retired_o), 32'd5);
        opcode_i = 6'b111111;
        cyc(1'b1);
        chk("ill_decode_state", 32'(state_o), 32'd1);
        chk("ill_decode_ctl", obs_ctl, ctl(10'b0000000000, 2'b11, 2'b00, 3'd0, 1'b1));
        cyc(1'b1);
        chk("ill_after_state", 32'(state_o), 32'd0);
        chk("ill_after_pulse", 32'(illegal_o), 32'd0);
        chk("ill_after_retired", 32'(retired_o), 32'd5);

        // ---- retire counter wrap via jumps ----
        opcode_i = 6'b000010;
        do_reset();
        cyc(1'b1);
        cyc(1'b1);
        chk("j_state", 32'(state_o), 32'd11);
        chk("j_ctl", obs_ctl, ctl(10'b1000000000, 2'b00, 2'b10, 3'd5, 1'b0));
        cyc(1'b1);
        chk("j_first_retired", 32'(retired_o), 32'd1);
        for (int i = 1; i < 65535; i++) begin
            cyc(1'b1);
            cyc(1'b1);
            cyc(1'b1);
        end
        chk("wrap_preload", 32'(retired_o), 32'hFFFF);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        chk("wrap_zero", 32'(retired_o), 32'h0000);

        // ---- asynchronous reset during MEMRD (with a wait cycle) ----
        opcode_i = 6'b000010;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        chk("pre_lw_retired", 32'(retired_o), 32'd1);
        opcode_i = 6'b100011;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        chk("memrd_wait1", 32'(state_o), 32'd3);
        cyc(1'b0);
        chk("memrd_wait2", 32'(state_o), 32'd3);
        #1;
        rst_i = 1'b0;
        #1;
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_retired", 32'(retired_o), 32'd0);
        chk("async_rst_illegal", 32'(illegal_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port opcode_i, input, 6 bits: instruction[31:26] from the instruction register.
REQ-005 The block SHALL have port funct_i, input, 6 bits: instruction[5:0] from the instruction register.
REQ-006 The block SHALL have port mem_ready_i, input, 1 bit: memory completes the current read or write this cycle.
REQ-007 The block SHALL have outputs PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o and ALUSrcA_o, each 1 bit, as datapath strobes and selects.
REQ-008 The block SHALL have outputs ALUSrcB_o and PCSource_o, each 2 bits: multiplexer selects.
REQ-009 The block SHALL have output ALUOp_o, 3 bits, encoded 0 add, 1 sub, 2 funct-decode, 3 addi, 4 slti, 5 jump.
REQ-010 The block SHALL have output state_o, 4 bits: current state, for debug.
REQ-011 The block SHALL have output illegal_o, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-012 The block SHALL have output retired_o, 16 bits: count of completed instructions.

Function
REQ-013 The block SHALL implement these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, IEX=9, IWB=10, JUMP=11, JR=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-014 Every output not listed for a state SHALL be 0.
REQ-015 In FETCH the block SHALL assert IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=0 and PCSource=00; it SHALL assert IRWrite=1 and PCWrite=1 combinationally only while mem_ready_i=1, then go to DECODE; otherwise it SHALL hold in FETCH.
REQ-016 In DECODE the block SHALL assert ALUSrcA=0, ALUSrcB=11 and ALUOp=0 (branch target), then dispatch: opcode 100011 or 101011 -> MEMADR; 000000 with funct 001000 -> JR; 000000 otherwise -> REX; 000100 -> BEQ; 001000 or 001010 -> IEX; 000010 -> JUMP.
REQ-017 In DECODE any other opcode SHALL pulse illegal_o for one cycle and return to FETCH without incrementing retired_o.
REQ-018 In MEMADR the block SHALL assert ALUSrcA=1, ALUSrcB=10 and ALUOp=0, then go to MEMRD when opcode=100011 and to MEMWR otherwise.
REQ-019 In MEMRD the block SHALL assert IorD=1 and MemRead=1, holding until mem_ready_i=1, then go to MEMWB.
REQ-020 In MEMWB the block SHALL assert RegDst=0, MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-021 In MEMWR the block SHALL assert IorD=1 and MemWrite=1, holding until mem_ready_i=1, then go to FETCH.
REQ-022 In REX the block SHALL assert ALUSrcA=1, ALUSrcB=00 and ALUOp=2, then go to RWB.
REQ-023 In RWB the block SHALL assert RegDst=1, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-024 In BEQ the block SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=1, PCWriteCond=1 and PCSource=01, then go to FETCH.
REQ-025 In IEX the block SHALL assert ALUSrcA=1 and ALUSrcB=10, with ALUOp=3 for opcode 001000 and ALUOp=4 for opcode 001010, then go to IWB.
REQ-026 In IWB the block SHALL assert RegDst=0, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-027 In JUMP the block SHALL assert PCWrite=1, PCSource=10 and ALUOp=5, then go to FETCH.
REQ-028 In JR the block SHALL assert ALUSrcA=1, ALUOp=2, PCWrite=1 and PCSource=11, then go to FETCH.
REQ-029 Instruction latency in cycles, with zero memory wait, SHALL be: lw 5, sw 4, R-type 4, addi/slti 4, beq 3, j 3, jr 3.
REQ-030 Each mem_ready_i=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle of latency.
REQ-031 retired_o SHALL increment by 1 on each edge leaving MEMWB, MEMWR (when mem_ready_i=1), RWB, BEQ, IWB, JUMP or JR, and SHALL wrap from 0xFFFF to 0x0000.
REQ-032 The block SHALL treat opcode_i and funct_i as stable from DECODE until the instruction completes, since IRWrite is asserted only in FETCH.

Reset
REQ-033 rst_i=0 SHALL force state=FETCH, retired_o=0 and illegal_o=0 immediately, independent of clk_i.
REQ-034 Reset asserted mid-instruction SHALL abandon the instruction with no retire increment.
REQ-035 After reset release the block SHALL drive the FETCH outputs, and SHALL not assert IRWrite or PCWrite until mem_ready_i=1.

Verification
REQ-036 Bench scenario: lw (100011) with mem_ready_i always 1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; retired_o becomes 1.
REQ-037 Bench scenario: sw (101011) with mem_ready_i low 2 cycles in MEMWR -> MemWrite=1 held 3 cycles; 6 cycles total; RegWrite never 1.
REQ-038 Bench scenario: R-type funct 100000, then R-type funct 001000 -> first passes 6->7 with ALUOp=2 and RegDst=1; second goes to state 12 with PCSource=11 and PCWrite=1; retired_o becomes 2.
REQ-039 Bench scenario: beq then slti (001010) -> BEQ asserts PCWriteCond=1 and ALUOp=1; IEX asserts ALUOp=4 and ALUSrcB=10.
REQ-040 Bench scenario: opcode 111111 -> illegal_o=1 for exactly one cycle, return to FETCH, retired_o unchanged.
REQ-041 Bench scenario: preload retired_o=0xFFFF via 65535 j instructions, then one j -> retired_o=0x0000; then rst_i=0 during MEMRD -> state_o=0 immediately.
